universal_shift_register: RTL and testbench

//   Parametrised shift register: hold, shift right, shift left, parallel load.

---
 rtl/universal_shift_register.sv | 119 +++++++++++
 tb/tb_universal_shift_register.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//   Parametrised shift register with hold, shift right, shift left and parallel
//   load. Counts shifts per frame (since last load or reset) and emits a
//   one-cycle frame_done pulse when the count reaches WIDTH. Intended as a
//   serializer/deserializer between parallel datapaths and 1-bit links.
//
// Parameters
//   WIDTH      register width in bits (>= 2)
//   RESET_VAL  value of q while/after reset
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   en         clock enable; 0 holds everything and suppresses frame_done
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   si         serial input bit
//   d          parallel load data
//   q          register contents (registered)
//   so_lsb     q[0], serial output for right shift
//   so_msb     q[WIDTH-1], serial output for left shift
//   shift_cnt  shifts since last load or reset, saturating at WIDTH
//   frame_done one-cycle pulse after the edge where shift_cnt reaches WIDTH
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         si,
  input  logic [WIDTH-1:0]             d,
  output logic [WIDTH-1:0]             q,
  output logic                         so_lsb,
  output logic                         so_msb,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         frame_done
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             done_nxt_s;
  logic             shift_s;

  // Next-state selection for data register and shift counter.
  always_comb begin
    q_nxt_s = q_r;
    shift_s = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:  q_nxt_s = q_r;
        MODE_RIGHT: begin
          q_nxt_s = {si, q_r[WIDTH-1:1]};
          shift_s = 1'b1;
        end
        MODE_LEFT: begin
          q_nxt_s = {q_r[WIDTH-2:0], si};
          shift_s = 1'b1;
        end
        MODE_LOAD:  q_nxt_s = d;
        default:    q_nxt_s = q_r;
      endcase
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Counter saturates at WIDTH; the pulse fires only on the WIDTH-1 -> WIDTH step,
  // so shifts beyond saturation never re-trigger it. Load clears the frame.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    done_nxt_s = 1'b0;
    if (en && (mode == MODE_LOAD)) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (shift_s && (cnt_r != CNT_MAX)) begin
      cnt_nxt_s  = cnt_r + CNT_ONE;
      done_nxt_s = (cnt_r == (CNT_MAX - CNT_ONE));
    end else begin
      cnt_nxt_s  = cnt_r;
      done_nxt_s = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= RESET_VAL;
      cnt_r  <= CNT_ZERO;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      cnt_r  <= cnt_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign q          = q_r;
  assign so_lsb     = q_r[0];
  assign so_msb     = q_r[WIDTH-1];
  assign shift_cnt  = cnt_r;
  assign frame_done = done_r;

endmodule

// File: tb/tb_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_register
//   Directed self-checking bench for universal_shift_register (WIDTH=8).
//   A second instance with RESET_VAL=8'h3C checks the reset value parameter.
// -----------------------------------------------------------------------------
module tb_universal_shift_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       si;
  logic [7:0] d;

  logic [7:0] q,  q2;
  logic       so_lsb, so_msb, so_lsb2, so_msb2;
  logic [3:0] shift_cnt, shift_cnt2;
  logic       frame_done, frame_done2;

  int checks;
  int errors;

  universal_shift_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .d(d),
    .q(q), .so_lsb(so_lsb), .so_msb(so_msb),
    .shift_cnt(shift_cnt), .frame_done(frame_done)
  );

  universal_shift_register #(.WIDTH(8), .RESET_VAL(8'h3C)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .d(d),
    .q(q2), .so_lsb(so_lsb2), .so_msb(so_msb2),
    .shift_cnt(shift_cnt2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input logic [3:0] ecnt,
                           input logic efd);
    chk({tag, "_q"},   32'(q),          32'(eq));
    chk({tag, "_cnt"}, 32'(shift_cnt),  32'(ecnt));
    chk({tag, "_fd"},  32'(frame_done), 32'(efd));
  endtask

  logic [7:0] pat;
  logic [7:0] bits;

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'b00;
    si   = 1'b0;
    d    = 8'h00;
    tick();
    tick();

    // ---- 1: reset values ----
    chk_state("rst_init", 8'h00, 4'd0, 1'b0);
    chk("rst_init_q2", 32'(q2), 32'h3C);
    chk("rst_init_so_msb2", 32'(so_msb2), 32'(1'b0));
    rst = 1'b0;
    en = 1'b1; mode = 2'b11; d = 8'hA5;
    tick();
    chk("load_a5_q", 32'(q), 32'hA5);
    chk("load_a5_so_lsb", 32'(so_lsb), 32'(1'b1));
    chk("load_a5_so_msb", 32'(so_msb), 32'(1'b1));
    chk("load_a5_q2", 32'(q2), 32'hA5);
    mode = 2'b00;
    // assert reset between edges: effect must be immediate
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 8'h00, 4'd0, 1'b0);
    chk("async_rst_q2", 32'(q2), 32'h3C);
    chk("async_rst_so_lsb", 32'(so_lsb), 32'(1'b0));
    chk("async_rst_so_msb", 32'(so_msb), 32'(1'b0));
    tick();
    rst = 1'b0;

    // ---- 2: serialize right, B4 LSB first ----
    mode = 2'b11; d = 8'hB4;
    tick();
    chk_state("ser_load", 8'hB4, 4'd0, 1'b0);
    mode = 2'b01; si = 1'b0;
    bits = 8'b1011_0100;           // so_lsb expected 0,0,1,0,1,1,0,1
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ser_so_lsb%0d", i), 32'(so_lsb), 32'(bits[i]));
      tick();
      chk($sformatf("ser_cnt%0d", i), 32'(shift_cnt), 32'(i + 1));
      chk($sformatf("ser_fd%0d", i), 32'(frame_done), 32'(i == 7));
    end
    chk("ser_q_end", 32'(q), 32'h00);
    mode = 2'b00;
    tick();
    chk_state("ser_after", 8'h00, 4'd8, 1'b0);

    // ---- 3: deserialize left from reset ----
    rst = 1'b1;
    #1 rst = 1'b0;
    chk_state("des_rst", 8'h00, 4'd0, 1'b0);
    mode = 2'b10;
    pat = 8'b1010_0111;            // si order 1,0,1,0,0,1,1,1
    for (int i = 0; i < 8; i++) begin
      si = pat[7 - i];
      tick();
      chk($sformatf("des_cnt%0d", i), 32'(shift_cnt), 32'(i + 1));
      chk($sformatf("des_fd%0d", i), 32'(frame_done), 32'(i == 7));
    end
    chk("des_q", 32'(q), 32'hA7);
    chk("des_so_msb", 32'(so_msb), 32'(1'b1));
    si = 1'b0;
    tick();
    chk_state("des_sat", 8'h4E, 4'd8, 1'b0);

    // ---- 4: enable / hold mid-frame ----
    mode = 2'b11; d = 8'hC3;
    tick();
    mode = 2'b01; si = 1'b1;
    tick(); tick(); tick();
    chk_state("hold_start", 8'hF8, 4'd3, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_state($sformatf("en0_%0d", i), 8'hF8, 4'd3, 1'b0);
    end
    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_state($sformatf("m00_%0d", i), 8'hF8, 4'd3, 1'b0);
    end
    mode = 2'b01; si = 1'b0;
    tick(); chk_state("resume1", 8'h7C, 4'd4, 1'b0);
    tick(); chk_state("resume2", 8'h3E, 4'd5, 1'b0);
    tick(); chk_state("resume3", 8'h1F, 4'd6, 1'b0);
    tick(); chk_state("resume4", 8'h0F, 4'd7, 1'b0);
    tick(); chk_state("resume5", 8'h07, 4'd8, 1'b1);
    mode = 2'b00;
    tick(); chk_state("resume_end", 8'h07, 4'd8, 1'b0);

    // ---- 5: load mid-frame ----
    mode = 2'b11; d = 8'hFF;
    tick();
    mode = 2'b10; si = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_state("ldmid_pre", 8'hC0, 4'd6, 1'b0);
    mode = 2'b11; d = 8'h0F;
    tick();
    chk_state("ldmid_load", 8'h0F, 4'd0, 1'b0);
    mode = 2'b01; si = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("ldmid_cnt%0d", i), 32'(shift_cnt), 32'(i + 1));
      chk($sformatf("ldmid_fd%0d", i), 32'(frame_done), 32'(i == 7));
    end
    chk("ldmid_q", 32'(q), 32'hFF);
    mode = 2'b00;
    tick();
    chk("ldmid_fd_after", 32'(frame_done), 32'(1'b0));

    // ---- 6: reset during the 8th shift cycle ----
    mode = 2'b11; d = 8'h81;
    tick();
    mode = 2'b10; si = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("rmid_fd%0d", i), 32'(frame_done), 32'(1'b0));
    end
    chk_state("rmid_pre", 8'h80, 4'd7, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_state("rmid_rst", 8'h00, 4'd0, 1'b0);
    mode = 2'b00;
    #1 rst = 1'b0;
    tick();
    chk_state("rmid_post1", 8'h00, 4'd0, 1'b0);
    tick();
    chk_state("rmid_post2", 8'h00, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
